// File: rtl/morse_tx_encoder_if.sv
// Character-descriptor port of the Morse transmitter: one descriptor (pattern/len or word space)
// moves from the character source (master) to the encoder (slave).
interface morse_tx_encoder_if #(
    parameter int MAX_LEN = 5,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    // Valid/ready: a descriptor transfers on a rising edge where in_valid & in_ready are both 1.
    // The source may drive anything while in_ready is 0; the encoder ignores it until it is idle again.
    logic               in_valid;
    logic               in_ready;
    logic               in_space;
    logic [LEN_W-1:0]   in_len;
    logic [MAX_LEN-1:0] in_pattern;

    modport master (
        output in_valid,
        output in_space,
        output in_len,
        output in_pattern,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_space,
        input  in_len,
        input  in_pattern,
        output in_ready
    );
endinterface

// File: rtl/morse_tx_encoder.sv
// Morse transmitter: turns one character descriptor into an on/off keying waveform with unit timing
// (dot 1, dash 3, element gap 1, char gap 3, word space 7 units) and pulses done on return to idle.
module morse_tx_encoder #(
    parameter int MAX_LEN    = 5,
    parameter int UNIT_TICKS = 6_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    morse_tx_encoder_if.slave    in_if,
    output logic                 key,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int TICK_W = $clog2(UNIT_TICKS) + 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(UNIT_TICKS - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX     = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        ELGAP = 2'd2,
        CHGAP = 2'd3
    } state_t;

    state_t             state_q;
    logic               key_q;
    logic               done_q;
    logic [TICK_W-1:0]  tick_q;
    logic [2:0]         units_q;
    logic [LEN_W-1:0]   elems_q;
    logic [MAX_LEN-1:0] pat_q;

    logic [LEN_W-1:0]   len_c;
    logic [MAX_LEN-1:0] pat_aligned;

    // Left-align the pattern so the first element sits in the MSB; later elements shift up into it.
    always_comb begin
        len_c       = (in_if.in_len > LEN_MAX) ? LEN_MAX : in_if.in_len;
        pat_aligned = in_if.in_pattern << (LEN_MAX - len_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= '0;
            units_q <= '0;
            elems_q <= '0;
            pat_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (in_if.in_valid) begin
                    tick_q <= TICK_RELOAD;
                    if (in_if.in_space) begin
                        state_q <= CHGAP;
                        units_q <= 3'd7;
                    end else if (len_c == '0) begin
                        state_q <= CHGAP;
                        units_q <= 3'd3;
                    end else begin
                        state_q <= MARK;
                        key_q   <= 1'b1;
                        units_q <= pat_aligned[MAX_LEN-1] ? 3'd3 : 3'd1;
                        pat_q   <= pat_aligned << 1;
                        elems_q <= len_c - LEN_W'(1);
                    end
                end
            end else if (tick_q != '0) begin
                tick_q <= tick_q - TICK_W'(1);
            end else begin
                // Unit boundary: prescaler reloads; the phase ends when its last unit expires.
                tick_q <= TICK_RELOAD;
                if (units_q != 3'd1) begin
                    units_q <= units_q - 3'd1;
                end else begin
                    case (state_q)
                        MARK: begin
                            key_q <= 1'b0;
                            if (elems_q != '0) begin
                                state_q <= ELGAP;
                                units_q <= 3'd1;
                            end else begin
                                state_q <= CHGAP;
                                units_q <= 3'd3;
                            end
                        end
                        ELGAP: begin
                            state_q <= MARK;
                            key_q   <= 1'b1;
                            units_q <= pat_q[MAX_LEN-1] ? 3'd3 : 3'd1;
                            pat_q   <= pat_q << 1;
                            elems_q <= elems_q - LEN_W'(1);
                        end
                        CHGAP: begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                        default: begin
                            state_q <= IDLE;
                            key_q   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign in_if.in_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign key            = key_q;
    assign done           = done_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_morse_tx_encoder.sv
// Directed bench for morse_tx_encoder at UNIT_TICKS=4: cycle-exact keying waveforms checked
// against hand-derived mark/space run lengths.
module tb_morse_tx_encoder;
    localparam int MAX_LEN    = 5;
    localparam int UNIT_TICKS = 4;

    logic       clk;
    logic       reset;
    logic       key;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    morse_tx_encoder_if #(.MAX_LEN(MAX_LEN)) in_if ();

    morse_tx_encoder #(
        .MAX_LEN   (MAX_LEN),
        .UNIT_TICKS(UNIT_TICKS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_if    (in_if),
        .key      (key),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a descriptor and wait for the accepting edge; returns #1 after it.
    task automatic send(input logic space, input logic [2:0] len, input logic [4:0] pat,
                        input logic hold);
        in_if.in_space   = space;
        in_if.in_len     = len;
        in_if.in_pattern = pat;
        in_if.in_valid   = 1'b1;
        @(negedge clk);
        check("accept_ready", 32'(in_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) in_if.in_valid = 1'b0;
    endtask

    // n consecutive busy cycles with key at a fixed level.
    task automatic seg(input string tag, input logic val, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_key"},  32'(key),  32'(val));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done"}, 32'(done), 32'd0);
            check({tag, "_rdy"},  32'(in_if.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic done_cycle(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_rdy"},  32'(in_if.in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_key"},  32'(key),  32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_rdy"},   32'(in_if.in_ready), 32'd1);
        check({tag, "_key"},   32'(key), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic char_a(input string tag);
        send(1'b0, 3'd2, 5'b00001, 1'b0);
        seg(tag, 1'b1, 4);
        seg(tag, 1'b0, 4);
        seg(tag, 1'b1, 12);
        seg(tag, 1'b0, 12);
        done_cycle(tag);
        idle_cycle(tag);
    endtask

    initial begin
        reset            = 1'b1;
        in_if.in_valid   = 1'b0;
        in_if.in_space   = 1'b0;
        in_if.in_len     = '0;
        in_if.in_pattern = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_key",   32'(key),  32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_rdy",   32'(in_if.in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycle("post_rst");

        // 'A': dot, dash
        char_a("A");

        // 'E' then 'T' with valid held; T is accepted on E's done cycle
        send(1'b0, 3'd1, 5'b00000, 1'b1);
        in_if.in_pattern = 5'b00001;
        seg("E", 1'b1, 4);
        seg("E", 1'b0, 12);
        done_cycle("E");
        in_if.in_valid = 1'b0;
        seg("T", 1'b1, 12);
        seg("T", 1'b0, 12);
        done_cycle("T");
        idle_cycle("T");

        // Word space, pattern/len ignored
        send(1'b1, 3'd5, 5'b11111, 1'b0);
        seg("space", 1'b0, 28);
        done_cycle("space");
        idle_cycle("space");

        // Zero-length character: char gap only
        send(1'b0, 3'd0, 5'b11111, 1'b0);
        seg("len0", 1'b0, 12);
        done_cycle("len0");
        idle_cycle("len0");

        // '5': five dots
        send(1'b0, 3'd5, 5'b00000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            seg("five", 1'b1, 4);
            seg("five", 1'b0, 4);
        end
        seg("five", 1'b1, 4);
        seg("five", 1'b0, 12);
        done_cycle("five");
        idle_cycle("five");

        // '0': five dashes
        send(1'b0, 3'd5, 5'b11111, 1'b0);
        for (int i = 0; i < 4; i++) begin
            seg("zero", 1'b1, 12);
            seg("zero", 1'b0, 4);
        end
        seg("zero", 1'b1, 12);
        seg("zero", 1'b0, 12);
        done_cycle("zero");
        idle_cycle("zero");

        // len=7 clamps to 5: dash dot dash dot dash; reset lands mid final dash
        send(1'b0, 3'd7, 5'b10101, 1'b0);
        seg("clamp", 1'b1, 12);
        seg("clamp", 1'b0, 4);
        seg("clamp", 1'b1, 4);
        seg("clamp", 1'b0, 4);
        seg("clamp", 1'b1, 12);
        seg("clamp", 1'b0, 4);
        seg("clamp", 1'b1, 4);
        seg("clamp", 1'b0, 4);
        seg("clamp", 1'b1, 6);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_key",   32'(key),  32'd0);
        check("midrst_rdy",   32'(in_if.in_ready), 32'd1);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_done",  32'(done), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) idle_cycle("after_rst");

        char_a("A2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
